register_file: RTL and testbench

Sixteen-entry, 32-bit general-purpose register file of the datapath; it is the consumer of the 4-bit register addresses produced by the A/B address multiplexers. It provides two combinational read ports, one synchronous write port, the program counter in R15 with auto-increment, and hardware link capture into R14. It sits between the address/operand multiplexers and the ALU operand inputs, with write-back from the result path.

---
 rtl/register_file.sv | 76 +++++++
 tb/tb_register_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Sixteen-entry general-purpose register file with two combinational read ports,
// one write port, program counter in R15 (auto-increment) and link capture into R14.
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            addr_a,
    input  logic [3:0]            addr_b,
    input  logic [3:0]            addr_w,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  pc_inc_enable,
    input  logic                  link_enable,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] pc_out
);

    localparam logic [3:0]            LINK_IDX  = 4'd14;
    localparam logic [3:0]            PC_IDX    = 4'd15;
    localparam logic [DATA_WIDTH-1:0] PC_STEP_W = DATA_WIDTH'(PC_STEP);

    logic [DATA_WIDTH-1:0] regs [16];

    logic write_link;
    logic write_pc;

    assign write_link = write_enable && (addr_w == LINK_IDX);
    assign write_pc   = write_enable && (addr_w == PC_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
            regs[15] <= PC_RESET;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (write_enable && (addr_w == 4'(i))) begin
                    regs[i] <= write_data;
                end
            end

            // Write port beats link capture; link samples R15 before this edge.
            if (write_link) begin
                regs[14] <= write_data;
            end else if (link_enable) begin
                regs[14] <= regs[15];
            end

            if (write_pc) begin
                regs[15] <= write_data;
            end else if (pc_inc_enable) begin
                regs[15] <= regs[15] + PC_STEP_W;
            end
        end
    end

    // Write-through bypass covers the write port only, not link/increment.
    always_comb begin
        data_a = regs[addr_a];
        data_b = regs[addr_b];
        if (write_enable && (addr_w == addr_a)) begin
            data_a = write_data;
        end
        if (write_enable && (addr_w == addr_b)) begin
            data_b = write_data;
        end
    end

    assign pc_out = regs[15];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, writes, bypass,
// PC increment/wrap, write-vs-increment priority and link capture.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [3:0]  addr_w;
    logic [31:0] write_data;
    logic        write_enable;
    logic        pc_inc_enable;
    logic        link_enable;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] pc_out;

    int checks   = 0;
    int failures = 0;

    register_file #(
        .DATA_WIDTH(32),
        .PC_RESET  (32'h0000_0000),
        .PC_STEP   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .addr_w       (addr_w),
        .write_data   (write_data),
        .write_enable (write_enable),
        .pc_inc_enable(pc_inc_enable),
        .link_enable  (link_enable),
        .data_a       (data_a),
        .data_b       (data_b),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        write_enable  = 1'b0;
        pc_inc_enable = 1'b0;
        link_enable   = 1'b0;
    endtask

    initial begin
        // Reset with every enable active: all must be ignored.
        reset         = 1'b1;
        write_enable  = 1'b1;
        addr_w        = 4'd3;
        write_data    = 32'hDEAD_BEEF;
        pc_inc_enable = 1'b1;
        link_enable   = 1'b1;
        addr_a        = 4'd0;
        addr_b        = 4'd0;
        tick();
        reset = 1'b0;
        idle();
        addr_a = 4'd3;
        addr_b = 4'd14;
        #1;
        check("reset_r3", data_a, 32'h0);
        check("reset_r14", data_b, 32'h0);
        check("reset_pc", pc_out, 32'h0);
        addr_a = 4'd15;
        #1;
        check("reset_read_r15", data_a, 32'h0);

        // Plain write then dual read of the same register.
        write_enable = 1'b1;
        addr_w       = 4'd5;
        write_data   = 32'h1234_5678;
        tick();
        idle();
        addr_a = 4'd5;
        addr_b = 4'd5;
        #1;
        check("r5_port_a", data_a, 32'h1234_5678);
        check("r5_port_b", data_b, 32'h1234_5678);

        // Same-cycle bypass on port A only.
        write_enable = 1'b1;
        addr_w       = 4'd7;
        write_data   = 32'hA5A5_A5A5;
        addr_a       = 4'd7;
        #1;
        check("bypass_a", data_a, 32'hA5A5_A5A5);
        check("no_bypass_b", data_b, 32'h1234_5678);
        tick();
        idle();
        write_data = 32'h0;
        #1;
        check("r7_stored", data_a, 32'hA5A5_A5A5);

        // Increment held three cycles, then released.
        pc_inc_enable = 1'b1;
        tick();
        check("pc_inc1", pc_out, 32'd4);
        tick();
        check("pc_inc2", pc_out, 32'd8);
        tick();
        check("pc_inc3", pc_out, 32'd12);
        idle();
        tick();
        check("pc_hold", pc_out, 32'd12);

        // Wrap at 2^32.
        write_enable = 1'b1;
        addr_w       = 4'd15;
        write_data   = 32'hFFFF_FFFC;
        tick();
        idle();
        check("pc_load_top", pc_out, 32'hFFFF_FFFC);
        pc_inc_enable = 1'b1;
        tick();
        idle();
        check("pc_wrap", pc_out, 32'h0);

        // Write port beats increment.
        pc_inc_enable = 1'b1;
        write_enable  = 1'b1;
        addr_w        = 4'd15;
        write_data    = 32'h100;
        tick();
        idle();
        check("pc_write_beats_inc", pc_out, 32'h100);

        // Link with simultaneous increment.
        write_enable = 1'b1;
        addr_w       = 4'd15;
        write_data   = 32'h40;
        tick();
        idle();
        link_enable   = 1'b1;
        pc_inc_enable = 1'b1;
        addr_a        = 4'd14;
        #1;
        check("link_no_bypass", data_a, 32'h0);
        tick();
        idle();
        #1;
        check("link_r14", data_a, 32'h40);
        check("link_pc", pc_out, 32'h44);

        // Write to R14 beats link on the same edge.
        link_enable   = 1'b1;
        pc_inc_enable = 1'b1;
        write_enable  = 1'b1;
        addr_w        = 4'd14;
        write_data    = 32'h99;
        tick();
        idle();
        #1;
        check("link_write_wins", data_a, 32'h99);
        check("link_write_pc", pc_out, 32'h48);

        // R15 read and R15 bypass; pc_out stays registered.
        write_enable = 1'b1;
        addr_w       = 4'd15;
        write_data   = 32'h20;
        tick();
        idle();
        addr_a = 4'd15;
        #1;
        check("read_r15", data_a, 32'h20);
        write_enable = 1'b1;
        write_data   = 32'h80;
        #1;
        check("bypass_r15", data_a, 32'h80);
        check("pc_out_no_bypass", pc_out, 32'h20);
        tick();
        idle();
        check("pc_after_write", pc_out, 32'h80);

        // Mid-sequence reset overrides write/increment/link.
        reset         = 1'b1;
        write_enable  = 1'b1;
        addr_w        = 4'd5;
        write_data    = 32'h1;
        pc_inc_enable = 1'b1;
        link_enable   = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        addr_a = 4'd5;
        addr_b = 4'd14;
        #1;
        check("rst2_r5", data_a, 32'h0);
        check("rst2_r14", data_b, 32'h0);
        check("rst2_pc", pc_out, 32'h0);

        // Operation resumes on the next edge.
        pc_inc_enable = 1'b1;
        tick();
        idle();
        check("resume_pc", pc_out, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
